// File: rtl/mul_err_pkg.sv
// Shared types and defaults for the approximate-multiplier error accumulator.
// Optional worst-case operand tracking: define MUL_ERR_WCE_TRACK_EN.
package mul_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FLUSH_CYCLES = 2;

    localparam int OP_W_DEF  = 6;
    localparam int CNT_W_DEF = 16;
    localparam int SUM_W_DEF = 28;

endpackage

// File: rtl/mul_err_diff.sv
// Stage 1: exact unsigned product and registered |p - a*b| with valid.
// With MUL_ERR_WCE_TRACK_EN the operands ride along for worst-case capture.
module mul_err_diff
    import mul_err_pkg::*;
#(
    parameter int OP_W = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [2*OP_W-1:0] p,
    output logic              out_valid,
    output logic [2*OP_W:0]   out_e
`ifdef MUL_ERR_WCE_TRACK_EN
    ,
    output logic [OP_W-1:0]   out_a,
    output logic [OP_W-1:0]   out_b
`endif
);

    localparam int PW = 2 * OP_W;
    localparam int EW = PW + 1;

    logic [PW-1:0] prod;
    logic [EW-1:0] ep;
    logic [EW-1:0] ex;
    logic [EW-1:0] e;

    assign prod = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
    assign ep   = {1'b0, p};
    assign ex   = {1'b0, prod};
    assign e    = (ep >= ex) ? (ep - ex) : (ex - ep);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_e     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_e <= e;
            end
        end
    end

`ifdef MUL_ERR_WCE_TRACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a <= '0;
            out_b <= '0;
        end else if (in_valid) begin
            out_a <= a;
            out_b <= b;
        end
    end
`endif

endmodule

// File: rtl/mul_err_accum.sv
// Error statistics for an approximate multiplier: counts, sum and max |error|.
// Define MUL_ERR_WCE_TRACK_EN to add wce_a/wce_b worst-case operand ports.
module mul_err_accum
    import mul_err_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [OP_W-1:0]   s_a,
    input  logic [OP_W-1:0]   s_b,
    input  logic [2*OP_W-1:0] s_p,
    input  logic              s_last,
    output logic              done,
    output logic [CNT_W-1:0]  samples,
    output logic [CNT_W-1:0]  mismatches,
    output logic [SUM_W-1:0]  sum_abs_err,
    output logic [2*OP_W-1:0] max_abs_err
`ifdef MUL_ERR_WCE_TRACK_EN
    ,
    output logic [OP_W-1:0]   wce_a,
    output logic [OP_W-1:0]   wce_b
`endif
);

    localparam int PW  = 2 * OP_W;
    localparam int EW  = PW + 1;
    localparam int AW  = ((SUM_W > EW) ? SUM_W : EW) + 1;
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    state_t         state;
    state_t         state_nx;
    logic [FCW-1:0] fcnt;
    logic           fire;
    logic           open_run;
    logic           d_valid;
    logic [EW-1:0]  d_e;
    logic [AW-1:0]  sum_wide;
    logic [SUM_W-1:0] sum_nx;
    logic           new_max;

    assign s_ready  = (state == RUN);
    assign done     = (state == DONE);
    assign fire     = s_valid & s_ready;
    assign open_run = start & ((state == IDLE) | (state == DONE));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (fire && s_last) state_nx = FLUSH;
            FLUSH:      if (fcnt == FCW'(FLUSH_CYCLES)) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= (state == FLUSH) ? fcnt + FCW'(1) : '0;
        end
    end

`ifdef MUL_ERR_WCE_TRACK_EN
    logic [OP_W-1:0] d_a;
    logic [OP_W-1:0] d_b;

    mul_err_diff #(.OP_W(OP_W)) u_diff (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fire),
        .a         (s_a),
        .b         (s_b),
        .p         (s_p),
        .out_valid (d_valid),
        .out_e     (d_e),
        .out_a     (d_a),
        .out_b     (d_b)
    );
`else
    mul_err_diff #(.OP_W(OP_W)) u_diff (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fire),
        .a         (s_a),
        .b         (s_b),
        .p         (s_p),
        .out_valid (d_valid),
        .out_e     (d_e)
    );
`endif

    // Widen so the add cannot wrap before the saturation test, even if SUM_W < EW.
    assign sum_wide = AW'(sum_abs_err) + AW'(d_e);
    assign sum_nx   = (sum_wide > AW'({SUM_W{1'b1}})) ? '1 : sum_wide[SUM_W-1:0];
    assign new_max  = d_e > EW'(max_abs_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples     <= '0;
            mismatches  <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (open_run) begin
            samples     <= '0;
            mismatches  <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (d_valid) begin
            if (!(&samples)) samples <= samples + CNT_W'(1);
            if (d_e != '0 && !(&mismatches)) mismatches <= mismatches + CNT_W'(1);
            sum_abs_err <= sum_nx;
            if (new_max) max_abs_err <= d_e[PW-1:0];
        end
    end

`ifdef MUL_ERR_WCE_TRACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wce_a <= '0;
            wce_b <= '0;
        end else if (open_run) begin
            wce_a <= '0;
            wce_b <= '0;
        end else if (d_valid && new_max) begin
            wce_a <= d_a;
            wce_b <= d_b;
        end
    end
`endif

endmodule
